// File: rtl/fetch_byte_queue.sv
// Byte-granular instruction queue: 16-byte fetch lines in, 15-byte decode window out.
// Optional same-cycle bypass of an incoming line into an empty queue: define FETCH_BYPASS_EN.
module fetch_byte_queue #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      line_valid,
    input  logic [8*LINE_BYTES-1:0]   line_data,
    input  logic [3:0]                line_skip,
    output logic                      line_ready,
    output logic [119:0]              win_bytes,
    output logic [3:0]                win_avail,
    output logic [31:0]               win_eip,
    input  logic                      dec_advance,
    input  logic [3:0]                dec_len,
    input  logic                      flush,
    input  logic [31:0]               flush_eip,
    output logic                      len_err
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned WIN = 15;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   eip_q, eip_d;
    logic          len_err_q, len_err_d;

    logic          push_c;
    logic [4:0]    push_len_c;
    logic [3:0]    avail_c;
    logic [119:0]  win_c;
    logic          legal_c;
    logic          illegal_c;
`ifdef FETCH_BYPASS_EN
    logic          bypass_c;
`endif

    // Acceptance depends only on registered occupancy; no credit for a same-cycle consume.
    always_comb begin
        line_ready = (count_q <= CW'(DEPTH - LINE_BYTES));
        push_len_c = 5'(LINE_BYTES) - 5'(line_skip);
        push_c     = line_valid && line_ready && !flush;
    end

    // Decode window: bytes beyond the valid count read as zero.
    always_comb begin
        avail_c = (count_q >= CW'(WIN)) ? 4'(WIN) : 4'(count_q);
        win_c   = '0;
`ifdef FETCH_BYPASS_EN
        bypass_c = (count_q == '0) && push_c;
        if (bypass_c) begin
            avail_c = (push_len_c > 5'(WIN)) ? 4'(WIN) : 4'(push_len_c);
        end
`endif
        for (int j = 0; j < int'(WIN); j++) begin
            if (4'(j) < avail_c) begin
`ifdef FETCH_BYPASS_EN
                if (bypass_c) begin
                    win_c[8*j +: 8] = line_data[8*(int'(line_skip) + j) +: 8];
                end else begin
                    win_c[8*j +: 8] = mem_q[PW'(head_q + PW'(j))];
                end
`else
                win_c[8*j +: 8] = mem_q[PW'(head_q + PW'(j))];
`endif
            end
        end
    end

    // Consume legality is judged on the window as presented this cycle.
    always_comb begin
        legal_c   = dec_advance && !flush && (dec_len != 4'd0) && (dec_len <= avail_c);
        illegal_c = dec_advance && !flush && !legal_c;
    end

    // Next-state: flush overrides any same-cycle push or consume.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        eip_d     = eip_q;
        len_err_d = len_err_q;
        mem_d     = mem_q;
        if (flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            eip_d     = flush_eip;
            len_err_d = 1'b0;
        end else begin
            if (push_c) begin
                tail_d = PW'(tail_q + PW'(push_len_c));
                for (int k = 0; k < int'(LINE_BYTES); k++) begin
                    if (4'(k) >= line_skip) begin
                        mem_d[PW'(tail_q + PW'(4'(k) - line_skip))] = line_data[8*k +: 8];
                    end
                end
            end
            if (legal_c) begin
                head_d = PW'(head_q + PW'(dec_len));
                eip_d  = eip_q + 32'(dec_len);
            end
            if (illegal_c) begin
                len_err_d = 1'b1;
            end
            count_d = count_q + (push_c ? CW'(push_len_c) : CW'(0))
                              - (legal_c ? CW'(dec_len) : CW'(0));
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            eip_q     <= '0;
            len_err_q <= 1'b0;
            mem_q     <= '{default: '0};
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            eip_q     <= eip_d;
            len_err_q <= len_err_d;
            mem_q     <= mem_d;
        end
    end

    assign win_bytes = win_c;
    assign win_avail = avail_c;
    assign win_eip   = eip_q;
    assign len_err   = len_err_q;

endmodule
